pipo_load_arbiter: RTL and testbench

Round-robin arbiter and load sequencer for a shared WIDTH-bit parallel-in/parallel-out holding register. Up to NREQ requesters compete to load the register. The block grants one requester per accepted load, captures its word, and presents it downstream with a valid/ready handshake. The word is held stable until it is consumed. It sits between the requester-side producers and the single downstream consumer of the register.

---
 rtl/pipo_load_arbiter.sv | 61 ++++++
 tb/tb_pipo_load_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/pipo_load_arbiter.sv
// pipo_load_arbiter: round-robin arbiter that loads one requester word per accepted load into a held output register
module pipo_load_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int SRCW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SRCW-1:0]       out_src,
    input  logic                  out_ready
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SRCW-1:0] src_q, src_d, ptr_q, ptr_d, gnt;
    logic any, load;
    // first requesting index at or after the pointer, wrapping around
    always_comb begin
        any = 1'b0;
        gnt = '0;
        for (int k = 0; k < NREQ; k++)
            if (!any && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                any = 1'b1;
                gnt = SRCW'((int'(ptr_q) + k) % NREQ);
            end
    end
    assign load = (state_q == EMPTY || out_ready) && any && !reset;
    // state register; reset discards any held word immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end
    // next state: a load wins over a drain so back-to-back reloads stay FULL
    always_comb begin
        state_d = load ? FULL : out_ready ? EMPTY : state_q;
        data_d  = load ? req_data[int'(gnt)*WIDTH +: WIDTH] : data_q;
        src_d   = load ? gnt : src_q;
        ptr_d   = load ? (gnt == SRCW'(NREQ-1) ? '0 : gnt + 1'b1) : ptr_q;
    end
    // outputs: grant is combinational, everything else comes from registers
    always_comb begin
        req_ready = load ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt) : '0;
        out_valid = state_q == FULL;
        out_data  = data_q;
        out_src   = src_q;
    end
endmodule

// File: tb/tb_pipo_load_arbiter.sv
// tb_pipo_load_arbiter: randomized and directed scoreboard bench for pipo_load_arbiter
module tb_pipo_load_arbiter;
    localparam int W = 4;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] req_ready;
    logic out_valid;
    logic [W-1:0] out_data;
    logic [1:0] out_src;
    logic out_ready = 1'b0;
    int vectors = 0;
    int errors = 0;
    logic [5:0] q[$];
    bit m_full = 0;
    logic [W-1:0] m_data = '0;
    int m_src = 0;
    int m_ptr = 0;

    pipo_load_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic step(input logic [N-1:0] rv, input logic [N*W-1:0] rd, input logic ordy);
        logic [N-1:0] er;
        int w;
        @(posedge clk); #1;
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_src", 32'(out_src), 32'(m_src));
        #1;
        req_valid = rv; req_data = rd; out_ready = ordy;
        er = '0;
        w = -1;
        if (!m_full || ordy)
            for (int k = 0; k < N; k++)
                if (w < 0 && rv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
            er[w] = 1'b1;
            m_data = rd[w*W +: W];
            m_src = w;
            m_ptr = (w + 1) % N;
            m_full = 1;
            q.push_back({2'(m_src), m_data});
        end else if (ordy) m_full = 0;
        #1 chk("req_ready", 32'(req_ready), 32'(er));
    endtask

    always @(negedge clk) begin
        logic [5:0] f;
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                errors++;
                vectors++;
                $display("FAIL consume: word %0h from %0d with empty scoreboard", out_data, out_src);
            end else begin
                f = q.pop_front();
                chk("consumed_data", 32'(out_data), 32'(f[3:0]));
                chk("consumed_src", 32'(out_src), 32'(f[5:4]));
            end
        end
    end

    initial begin
        #1;
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_data", 32'(out_data), 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) step('0, '0, 1'b0);
        step(4'b0100, 16'h0500, 1'b0);
        repeat (3) step(4'b0100, 16'h0900, 1'b0);
        repeat (9) step(4'b1111, 16'h4321, 1'b1);
        step(4'b0100, 16'h0600, 1'b1);
        repeat (2) step(4'b0011, 16'h00C8, 1'b1);
        step(4'b0001, 16'h0007, 1'b1);
        repeat (5) step(4'b1110, 16'h9AB0, 1'b0);
        step(4'b1110, 16'h9AB0, 1'b1);
        repeat (3) step('0, '0, 1'b1);
        for (int i = 0; i < 300; i++)
            step(N'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) != 0);
        step(4'b0001, 16'h000A, 1'b1);
        step(4'b0001, 16'h000B, 1'b0);
        #4 reset = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_data", 32'(out_data), 0);
        chk("async_src", 32'(out_src), 0);
        chk("async_ready", 32'(req_ready), 0);
        q.delete();
        m_full = 0; m_data = '0; m_src = 0; m_ptr = 0;
        req_valid = '0; out_ready = 1'b0;
        #1 reset = 1'b0;
        repeat (3) step('0, '0, 1'b0);
        repeat (20) step(N'($urandom_range(0, 15)), 16'($urandom), 1'b1);
        repeat (3) step('0, '0, 1'b1);
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
